// File: rtl/rv32_dmem_pkg.sv
// Shared constants and access classification for the rv32 data memory.
// GPIO addresses are only decoded when RV32_DMEM_MMIO_EN is defined.
package rv32_dmem_pkg;

  localparam int unsigned DMEM_DEPTH    = 1024;
  localparam logic [31:0] GPIO_OUT_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] GPIO_IN_ADDR  = 32'hFFFF_FF04;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_LOAD,
    ACC_STORE,
    ACC_MMIO,
    ACC_ERR
  } acc_class_e;

  function automatic logic is_mmio_addr(input logic [31:0] addr);
    return (addr == GPIO_OUT_ADDR) || (addr == GPIO_IN_ADDR);
  endfunction

endpackage

// File: rtl/rv32_data_mem_if.sv
// Core-to-data-memory bus. GPIO signals exist only with RV32_DMEM_MMIO_EN.
interface rv32_data_mem_if #(
  parameter int unsigned ERR_W = 8
);
  logic             data_mem_enable;
  logic             data_mem_read;
  logic [31:0]      data_addr_bus;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic             misalign;
  logic [ERR_W-1:0] err_count;
`ifdef RV32_DMEM_MMIO_EN
  logic [15:0]      gpio_out;
  logic [15:0]      gpio_in;

  modport master (
    output data_mem_enable, data_mem_read, data_addr_bus, write_data, gpio_in,
    input  read_data, misalign, err_count, gpio_out
  );

  modport slave (
    input  data_mem_enable, data_mem_read, data_addr_bus, write_data, gpio_in,
    output read_data, misalign, err_count, gpio_out
  );
`else
  modport master (
    output data_mem_enable, data_mem_read, data_addr_bus, write_data,
    input  read_data, misalign, err_count
  );

  modport slave (
    input  data_mem_enable, data_mem_read, data_addr_bus, write_data,
    output read_data, misalign, err_count
  );
`endif
endinterface

// File: rtl/rv32_dmem_wbuf.sv
// One-entry posted write buffer: captures a store, drains it on the next edge,
// and forwards its data to a load of the same word index.
module rv32_dmem_wbuf #(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cap,
  input  logic [IDX_W-1:0] i_cap_idx,
  input  logic [31:0]      i_cap_data,
  input  logic [IDX_W-1:0] i_ld_idx,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic [31:0]      o_wr_data,
  output logic             o_fwd_hit,
  output logic [31:0]      o_fwd_data
);

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_data;

  // Drain and capture share an edge, so the buffer never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= i_cap;
      if (i_cap) begin
        r_idx  <= i_cap_idx;
        r_data <= i_cap_data;
      end
    end
  end

  assign o_wr_en    = r_valid;
  assign o_wr_idx   = r_idx;
  assign o_wr_data  = r_data;
  assign o_fwd_hit  = r_valid && (r_idx == i_ld_idx);
  assign o_fwd_data = r_data;

endmodule

// File: rtl/rv32_data_mem.sv
// Word-addressed data memory with posted write buffer and error tracking.
// Optional GPIO window enabled by defining RV32_DMEM_MMIO_EN.
module rv32_data_mem
  import rv32_dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned ERR_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  rv32_data_mem_if.slave bus
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_read_data;
  logic             r_misalign;
  logic [ERR_W-1:0] r_err_count;

  acc_class_e       w_acc;
  logic             w_misal;
  logic             w_in_range;
  logic             w_is_mmio;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [31:0]      w_wr_data;
  logic             w_fwd_hit;
  logic [31:0]      w_fwd_data;
  logic [31:0]      w_mmio_rdata;

  assign w_idx      = bus.data_addr_bus[IDX_W+1:2];
  assign w_misal    = bus.data_addr_bus[1:0] != 2'b00;
  assign w_in_range = {1'b0, bus.data_addr_bus} < ADDR_LIMIT;

`ifdef RV32_DMEM_MMIO_EN
  assign w_is_mmio = is_mmio_addr(bus.data_addr_bus);
`else
  assign w_is_mmio = 1'b0;
`endif

  // Misalignment outranks every other classification.
  always_comb begin
    w_acc = ACC_NONE;
    if (bus.data_mem_enable) begin
      if (w_misal)               w_acc = ACC_ERR;
      else if (w_is_mmio)        w_acc = ACC_MMIO;
      else if (!w_in_range)      w_acc = ACC_ERR;
      else if (bus.data_mem_read) w_acc = ACC_LOAD;
      else                       w_acc = ACC_STORE;
    end
  end

  rv32_dmem_wbuf #(
    .IDX_W (IDX_W)
  ) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cap      (w_acc == ACC_STORE),
    .i_cap_idx  (w_idx),
    .i_cap_data (bus.write_data),
    .i_ld_idx   (w_idx),
    .o_wr_en    (w_wr_en),
    .o_wr_idx   (w_wr_idx),
    .o_wr_data  (w_wr_data),
    .o_fwd_hit  (w_fwd_hit),
    .o_fwd_data (w_fwd_data)
  );

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data <= '0;
    end else begin
      case (w_acc)
        ACC_LOAD: r_read_data <= w_fwd_hit ? w_fwd_data : r_mem[w_idx];
        ACC_MMIO: if (bus.data_mem_read) r_read_data <= w_mmio_rdata;
        ACC_ERR:  if (bus.data_mem_read && !w_misal) r_read_data <= '0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (bus.data_mem_enable && w_misal) r_misalign <= 1'b1;
      if (w_acc == ACC_ERR && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
    end
  end

`ifdef RV32_DMEM_MMIO_EN
  logic [15:0] r_gpio_out;
  logic [15:0] r_gpio_sync1;
  logic [15:0] r_gpio_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_out   <= '0;
      r_gpio_sync1 <= '0;
      r_gpio_sync2 <= '0;
    end else begin
      r_gpio_sync1 <= bus.gpio_in;
      r_gpio_sync2 <= r_gpio_sync1;
      if (w_acc == ACC_MMIO && !bus.data_mem_read && bus.data_addr_bus == GPIO_OUT_ADDR) begin
        r_gpio_out <= bus.write_data[15:0];
      end
    end
  end

  always_comb begin
    w_mmio_rdata = '0;
    if (bus.data_addr_bus == GPIO_OUT_ADDR) w_mmio_rdata = {16'b0, r_gpio_out};
    else                                   w_mmio_rdata = {16'b0, r_gpio_sync2};
  end

  assign bus.gpio_out = r_gpio_out;
`else
  assign w_mmio_rdata = '0;
`endif

  assign bus.read_data = r_read_data;
  assign bus.misalign  = r_misalign;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_rv32_data_mem.sv
// Directed self-checking bench for rv32_data_mem (either RV32_DMEM_MMIO_EN build).
module tb_rv32_data_mem;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rv32_data_mem_if #(.ERR_W(8)) bus_if ();

  rv32_data_mem #(
    .DEPTH (1024),
    .ERR_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access per cycle; outputs are sampled 1 time unit after the edge.
  task automatic access(input logic rd, input logic [31:0] addr, input logic [31:0] data);
    bus_if.data_mem_enable = 1'b1;
    bus_if.data_mem_read   = rd;
    bus_if.data_addr_bus   = addr;
    bus_if.write_data      = data;
    @(posedge clk);
    #1;
    bus_if.data_mem_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_if.data_mem_enable = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    n_checks += 3;
    if (bus_if.read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got=%h exp=%h", bus_if.read_data, 32'h0);
    end
    if (bus_if.misalign !== 1'b0) begin
      n_fail++; $display("FAIL reset_misalign got=%b exp=0", bus_if.misalign);
    end
    if (bus_if.err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_err got=%0d exp=0", bus_if.err_count);
    end
    rst_n = 1'b1;
    idle(1);
    access(1'b0, 32'h0, 32'h1111_1111);
    idle(2);
    access(1'b1, 32'h0, 32'h0);
    n_checks += 3;
    if (bus_if.read_data !== 32'h1111_1111) begin
      n_fail++; $display("FAIL init_load got=%h exp=%h", bus_if.read_data, 32'h1111_1111);
    end
    if (bus_if.misalign !== 1'b0) begin
      n_fail++; $display("FAIL init_misalign got=%b exp=0", bus_if.misalign);
    end
    if (bus_if.err_count !== 8'd0) begin
      n_fail++; $display("FAIL init_err got=%0d exp=0", bus_if.err_count);
    end
  endtask

  task automatic test_forward;
    access(1'b0, 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 32'h10, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fwd_load got=%h exp=%h", bus_if.read_data, 32'hDEAD_BEEF);
    end
    idle(2);
    access(1'b1, 32'h10, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL array_load got=%h exp=%h", bus_if.read_data, 32'hDEAD_BEEF);
    end
    access(1'b0, 32'h10, 32'h0BAD_0BAD);
    idle(3);
    n_checks++;
    if (bus_if.read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL hold_rdata got=%h exp=%h", bus_if.read_data, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_back_to_back;
    access(1'b0, 32'h20, 32'h1);
    access(1'b0, 32'h20, 32'h2);
    access(1'b0, 32'h20, 32'h3);
    access(1'b1, 32'h20, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'h3) begin
      n_fail++; $display("FAIL b2b_fwd got=%h exp=%h", bus_if.read_data, 32'h3);
    end
    idle(2);
    access(1'b1, 32'h20, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'h3) begin
      n_fail++; $display("FAIL b2b_array got=%h exp=%h", bus_if.read_data, 32'h3);
    end
    access(1'b0, 32'h20, 32'hA);
    access(1'b0, 32'h24, 32'hB);
    access(1'b0, 32'h20, 32'hC);
    access(1'b0, 32'h24, 32'hD);
    access(1'b1, 32'h24, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'hD) begin
      n_fail++; $display("FAIL mix_fwd_24 got=%h exp=%h", bus_if.read_data, 32'hD);
    end
    access(1'b1, 32'h20, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'hC) begin
      n_fail++; $display("FAIL mix_arr_20 got=%h exp=%h", bus_if.read_data, 32'hC);
    end
    access(1'b1, 32'h24, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'hD) begin
      n_fail++; $display("FAIL mix_arr_24 got=%h exp=%h", bus_if.read_data, 32'hD);
    end
  endtask

  task automatic test_errors;
    access(1'b1, 32'h13, 32'h0);
    n_checks += 3;
    if (bus_if.read_data !== 32'hD) begin
      n_fail++; $display("FAIL misal_rdata got=%h exp=%h", bus_if.read_data, 32'hD);
    end
    if (bus_if.misalign !== 1'b1) begin
      n_fail++; $display("FAIL misal_flag got=%b exp=1", bus_if.misalign);
    end
    if (bus_if.err_count !== 8'd1) begin
      n_fail++; $display("FAIL misal_err got=%0d exp=1", bus_if.err_count);
    end
    access(1'b0, 32'h22, 32'h0000_0BAD);
    access(1'b1, 32'h20, 32'h0);
    n_checks += 2;
    if (bus_if.read_data !== 32'hC) begin
      n_fail++; $display("FAIL misal_store_drop got=%h exp=%h", bus_if.read_data, 32'hC);
    end
    if (bus_if.err_count !== 8'd2) begin
      n_fail++; $display("FAIL misal_store_err got=%0d exp=2", bus_if.err_count);
    end
    access(1'b1, 32'h1000, 32'h0);
    n_checks += 2;
    if (bus_if.read_data !== 32'h0) begin
      n_fail++; $display("FAIL oor_load got=%h exp=0", bus_if.read_data);
    end
    if (bus_if.err_count !== 8'd3) begin
      n_fail++; $display("FAIL oor_load_err got=%0d exp=3", bus_if.err_count);
    end
    access(1'b0, 32'hFFC, 32'hCAFE_F00D);
    access(1'b1, 32'hFFC, 32'h0);
    n_checks += 2;
    if (bus_if.read_data !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL last_word got=%h exp=%h", bus_if.read_data, 32'hCAFE_F00D);
    end
    if (bus_if.err_count !== 8'd3) begin
      n_fail++; $display("FAIL last_word_err got=%0d exp=3", bus_if.err_count);
    end
    access(1'b0, 32'h1000, 32'h0000_0BAD);
    idle(2);
    access(1'b1, 32'h0, 32'h0);
    n_checks += 2;
    if (bus_if.read_data !== 32'h1111_1111) begin
      n_fail++; $display("FAIL oor_alias got=%h exp=%h", bus_if.read_data, 32'h1111_1111);
    end
    if (bus_if.err_count !== 8'd4) begin
      n_fail++; $display("FAIL oor_store_err got=%0d exp=4", bus_if.err_count);
    end
    for (int i = 0; i < 300; i++) access(1'b0, 32'h2000, 32'(i));
    n_checks++;
    if (bus_if.err_count !== 8'd255) begin
      n_fail++; $display("FAIL err_sat got=%0d exp=255", bus_if.err_count);
    end
    access(1'b1, 32'h2001, 32'h0);
    access(1'b0, 32'h4000, 32'h0);
    n_checks += 2;
    if (bus_if.err_count !== 8'd255) begin
      n_fail++; $display("FAIL err_hold got=%0d exp=255", bus_if.err_count);
    end
    if (bus_if.misalign !== 1'b1) begin
      n_fail++; $display("FAIL misal_sticky got=%b exp=1", bus_if.misalign);
    end
  endtask

  task automatic test_reset_mid;
    access(1'b0, 32'h14, 32'h5555_5555);
    idle(2);
    access(1'b1, 32'h14, 32'h0);
    access(1'b0, 32'h14, 32'h6666_6666);
    rst_n = 1'b0;
    #3;
    n_checks += 3;
    if (bus_if.read_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata got=%h exp=0", bus_if.read_data);
    end
    if (bus_if.misalign !== 1'b0) begin
      n_fail++; $display("FAIL rst_misalign got=%b exp=0", bus_if.misalign);
    end
    if (bus_if.err_count !== 8'd0) begin
      n_fail++; $display("FAIL rst_err got=%0d exp=0", bus_if.err_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    access(1'b1, 32'h14, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'h5555_5555) begin
      n_fail++; $display("FAIL rst_lost_store got=%h exp=%h", bus_if.read_data, 32'h5555_5555);
    end
  endtask

  task automatic test_mmio;
`ifdef RV32_DMEM_MMIO_EN
    n_checks++;
    if (bus_if.gpio_out !== 16'h0) begin
      n_fail++; $display("FAIL gpio_rst got=%h exp=0", bus_if.gpio_out);
    end
    access(1'b0, 32'hFFFF_FF00, 32'h0000_A5A5);
    n_checks++;
    if (bus_if.gpio_out !== 16'hA5A5) begin
      n_fail++; $display("FAIL gpio_out got=%h exp=%h", bus_if.gpio_out, 16'hA5A5);
    end
    bus_if.gpio_in = 16'h1234;
    idle(2);
    access(1'b1, 32'hFFFF_FF04, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'h0000_1234) begin
      n_fail++; $display("FAIL gpio_in got=%h exp=%h", bus_if.read_data, 32'h0000_1234);
    end
    access(1'b1, 32'hFFFF_FF00, 32'h0);
    n_checks++;
    if (bus_if.read_data !== 32'h0000_A5A5) begin
      n_fail++; $display("FAIL gpio_out_rd got=%h exp=%h", bus_if.read_data, 32'h0000_A5A5);
    end
    access(1'b0, 32'hFFFF_FF04, 32'hFFFF_FFFF);
    n_checks += 2;
    if (bus_if.err_count !== 8'd0) begin
      n_fail++; $display("FAIL gpio_in_store_err got=%0d exp=0", bus_if.err_count);
    end
    if (bus_if.gpio_out !== 16'hA5A5) begin
      n_fail++; $display("FAIL gpio_in_store got=%h exp=%h", bus_if.gpio_out, 16'hA5A5);
    end
`else
    access(1'b0, 32'hFFFF_FF00, 32'h0000_A5A5);
    n_checks++;
    if (bus_if.err_count !== 8'd1) begin
      n_fail++; $display("FAIL nommio_store_err got=%0d exp=1", bus_if.err_count);
    end
    access(1'b1, 32'hFFFF_FF04, 32'h0);
    n_checks += 2;
    if (bus_if.read_data !== 32'h0) begin
      n_fail++; $display("FAIL nommio_load got=%h exp=0", bus_if.read_data);
    end
    if (bus_if.err_count !== 8'd2) begin
      n_fail++; $display("FAIL nommio_load_err got=%0d exp=2", bus_if.err_count);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.data_mem_enable = 1'b0;
    bus_if.data_mem_read   = 1'b0;
    bus_if.data_addr_bus   = 32'h0;
    bus_if.write_data      = 32'h0;
`ifdef RV32_DMEM_MMIO_EN
    bus_if.gpio_in = 16'h0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_forward();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_mmio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_data_mem.md
# rv32_data_mem

Word-addressed on-chip data memory with a one-entry posted write buffer, sitting directly downstream of the `rv32_cpu_top` data port. It consumes `data_mem_enable`, `data_mem_read`, `data_addr_bus` and `write_data`, and returns `read_data` to the core. It detects misaligned and out-of-range accesses, and optionally exposes a 16-bit GPIO window for board bring-up.

## Interface
Parameters:
- `DEPTH`, default 1024: number of 32-bit words; must be a power of two.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low. Clock is `clk`, reset is `rst_n`.
- `data_mem_enable`  in  1  access request this cycle.
- `data_mem_read`  in  1  1 = load, 0 = store; qualified by enable.
- `data_addr_bus`  in  32  byte address.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result, registered.
- `misalign`  out  1  sticky flag: a misaligned access occurred.
- `err_count`  out  ERR_W  saturating count of dropped accesses (misaligned or out of range).
- `gpio_out`  out  16  MMIO output register; present only with `RV32_DMEM_MMIO_EN`.
- `gpio_in`  in  16  asynchronous board inputs; present only with `RV32_DMEM_MMIO_EN`.

## Operation
- Word index is `data_addr_bus[log2(DEPTH)+1:2]`.
- In range: `data_addr_bus < DEPTH*4`.
- Misaligned: `data_addr_bus[1:0] != 0`. The access is dropped, `misalign` is set, and `err_count` increments. Misalignment takes priority over the range check.
- Out-of-range load: returns 0 and increments `err_count`.
- Out-of-range store: dropped and increments `err_count`.
- Store (enable=1, read=0, valid): captured into the write buffer `{wb_valid, wb_idx, wb_data}`. The array is not written on that edge.
- Write-buffer drain: on any edge where `wb_valid`=1, the buffered entry is written to the array.
  - If a new valid store arrives on the same edge, the old entry drains and the new one is captured in the same edge. The buffer never stalls.
  - Otherwise `wb_valid` clears.
- Load (enable=1, read=1, valid): the array is read synchronously.
  - If `wb_valid` and `wb_idx` equals the load index, `wb_data` is forwarded instead of the array data.
- With enable=0, `read_data` holds its last value.
- `err_count` saturates at all ones; it never wraps.

Reset values:
- `read_data` = 0, `misalign` = 0, `err_count` = 0, `wb_valid` = 0, `gpio_out` = 0.
- Array contents are not reset.
- Reset asserted mid-operation discards any buffered store; that store is lost by design.

## Timing
- Load latency is 1 cycle: address presented in cycle N, `read_data` valid after the rising edge ending cycle N and held until the next load.
- A store in cycle N is visible to a load in cycle N+1 through forwarding, and to any later load through the array or forwarding.
- Back-to-back stores to the same word: the last store wins, with the array and buffer kept consistent.
- The array has 1 write port and 1 synchronous read port, inferable as block RAM.
- A same-edge drain and read of the same index never occurs unforwarded, because forwarding covers that case.
- The error flag and error count update on the same edge as the dropped access.

## Configuration
- `RV32_DMEM_MMIO_EN` defined:
  - Address `0xFFFF_FF00`: a store writes `write_data[15:0]` to `gpio_out`; a load returns `{16'b0, gpio_out}`.
  - Address `0xFFFF_FF04`: a load returns `{16'b0, gpio_in_sync}`, where `gpio_in` passes through a two-flop synchronizer reset to 0. Stores to this address are ignored, with no error.
  - MMIO accesses bypass the write buffer and the array, with the same 1-cycle load latency.
- `RV32_DMEM_MMIO_EN` undefined:
  - The GPIO ports and registers are absent.
  - Both addresses are treated as ordinary out-of-range accesses.

## Structure
- Shared package `rv32_dmem_pkg` holds:
  - `GPIO_OUT_ADDR` and `GPIO_IN_ADDR` constants.
  - The access-class enum `{ACC_NONE, ACC_LOAD, ACC_STORE, ACC_MMIO, ACC_ERR}`.
  - The default `DEPTH`.
- Sub-module `rv32_dmem_wbuf`: the one-entry write buffer containing capture/drain control and the forward-match compare. The top holds the decode, array, error logic and MMIO.

## Test plan
- Reset, then a load from word 0 with an initialized array → `read_data`=initial value; `misalign`=0, `err_count`=0.
- Store `0xDEADBEEF` to `0x10`, then a load of `0x10` in the very next cycle → `read_data`=`0xDEADBEEF` via forwarding. A load of `0x10` three cycles later returns the same value from the array.
- Stores `0x1`, `0x2`, `0x3` to `0x20` on consecutive cycles, then a load of `0x20` → `0x3`; no intervening store is lost when interleaved with stores to `0x24`.
- Load `0x13` → `misalign`=1, `err_count`=1, `read_data` unchanged. Then 300 out-of-range stores → `err_count`=255 and it stays there.
- Store to `0x14`, then assert `rst_n`=0 on the next cycle and release → a load of `0x14` returns the pre-store contents; all outputs read 0 after reset.
- With `RV32_DMEM_MMIO_EN`: store `0x0000A5A5` to `0xFFFF_FF00` → `gpio_out`=`0xA5A5`. Drive `gpio_in`=`0x1234`, wait 2 cycles, load `0xFFFF_FF04` → `0x00001234`. Without the macro, the same store increments `err_count`.
